// File: rtl/lock_if.sv
// Key-flag and lock-status bundle between the key filter bank and lock_ctrl.
// The filter side drives the one-cycle flags; lock_ctrl drives the status outputs.
interface lock_if;
  logic       digit_flag;
  logic [3:0] digit_val;
  logic       enter_flag;
  logic       clear_flag;
  logic       set_flag;
  logic       unlocked;
  logic       alarm;
  logic       err_pulse;
  logic [3:0] digit_cnt;

  modport master (
    output digit_flag, digit_val, enter_flag, clear_flag, set_flag,
    input  unlocked, alarm, err_pulse, digit_cnt
  );

  modport slave (
    input  digit_flag, digit_val, enter_flag, clear_flag, set_flag,
    output unlocked, alarm, err_pulse, digit_cnt
  );
endinterface

// File: rtl/lock_ctrl.sv
// Password-lock sequencer: collects a BCD code entry, checks it against the stored
// code and sequences unlock, auto-relock, code change and lockout.
module lock_ctrl #(
  parameter int unsigned              CODE_LEN     = 4,
  parameter int unsigned              MAX_FAIL     = 3,
  parameter int unsigned              UNLOCK_CYC   = 500,
  parameter int unsigned              LOCKOUT_CYC  = 1000,
  parameter int unsigned              TIMER_W      = 20,
  parameter logic [4*CODE_LEN-1:0]    DEFAULT_CODE = 16'h1234
) (
  input  logic  Clk,
  input  logic  Rst_n,
  lock_if.slave bus
);

  localparam int unsigned CODE_W = 4 * CODE_LEN;
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [2:0] S_LOCKED  = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_SETPW   = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  logic [2:0]         state;
  logic [CODE_W-1:0]  code;
  logic [CODE_W-1:0]  buffer;
  logic [3:0]         digit_cnt;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [TIMER_W-1:0] timer;
  logic               unlocked;
  logic               alarm;
  logic               err_pulse;

  logic              full;
  logic              digit_ok;
  logic [CODE_W-1:0] buffer_shift;

  assign full         = (digit_cnt == 4'(CODE_LEN));
  assign digit_ok     = bus.digit_flag && (bus.digit_val <= 4'd9) && !full;
  assign buffer_shift = (buffer << 4) | CODE_W'(bus.digit_val);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; err_pulse is defaulted low each cycle before the state case.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_LOCKED;
      code      <= DEFAULT_CODE;
      buffer    <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
      unlocked  <= 1'b0;
      alarm     <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_LOCKED: begin
          if (bus.clear_flag) begin
            buffer    <= '0;
            digit_cnt <= '0;
          end else if (bus.enter_flag) begin
            state <= S_CHECK;
          end else if (!bus.set_flag && digit_ok) begin
            buffer    <= buffer_shift;
            digit_cnt <= digit_cnt + 4'd1;
          end
        end

        S_CHECK: begin
          buffer    <= '0;
          digit_cnt <= '0;
          if (full && (buffer == code)) begin
            state    <= S_OPEN;
            unlocked <= 1'b1;
            fail_cnt <= '0;
            timer    <= TIMER_W'(UNLOCK_CYC - 1);
          end else begin
            err_pulse <= 1'b1;
            if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
              state    <= S_LOCKOUT;
              alarm    <= 1'b1;
              fail_cnt <= '0;
              timer    <= TIMER_W'(LOCKOUT_CYC - 1);
            end else begin
              state    <= S_LOCKED;
              fail_cnt <= fail_cnt + 1'b1;
            end
          end
        end

        // Auto-relock expiry takes precedence over any key flag in the same cycle.
        S_OPEN: begin
          if (timer == '0) begin
            state    <= S_LOCKED;
            unlocked <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
            if (bus.clear_flag) begin
              buffer    <= '0;
              digit_cnt <= '0;
            end else if (bus.enter_flag) begin
              state    <= S_LOCKED;
              unlocked <= 1'b0;
            end else if (bus.set_flag) begin
              state     <= S_SETPW;
              buffer    <= '0;
              digit_cnt <= '0;
            end
          end
        end

        S_SETPW: begin
          if (bus.clear_flag) begin
            state     <= S_LOCKED;
            unlocked  <= 1'b0;
            buffer    <= '0;
            digit_cnt <= '0;
          end else if (bus.enter_flag) begin
            buffer    <= '0;
            digit_cnt <= '0;
            if (full) begin
              code     <= buffer;
              state    <= S_LOCKED;
              unlocked <= 1'b0;
            end else begin
              err_pulse <= 1'b1;
            end
          end else if (!bus.set_flag && digit_ok) begin
            buffer    <= buffer_shift;
            digit_cnt <= digit_cnt + 4'd1;
          end
        end

        S_LOCKOUT: begin
          if (timer == '0) begin
            state <= S_LOCKED;
            alarm <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state     <= S_LOCKED;
          buffer    <= '0;
          digit_cnt <= '0;
          fail_cnt  <= '0;
          timer     <= '0;
          unlocked  <= 1'b0;
          alarm     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlocked  = unlocked;
  assign bus.alarm     = alarm;
  assign bus.err_pulse = err_pulse;
  assign bus.digit_cnt = digit_cnt;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl: a per-cycle vector table for single-cycle behaviour,
// then hand-written sequences for relock timing, lockout, code change and reset.
module tb_lock_ctrl;

  logic Clk;
  logic Rst_n;
  int   n_pass;
  int   n_total;

  lock_if bus ();

  lock_ctrl dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       df;
    logic [3:0] dv;
    logic       ef;
    logic       cf;
    logic       sf;
    logic       exp_unl;
    logic       exp_alm;
    logic       exp_err;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a falling edge: drive flags for one rising edge, return at the next falling edge.
  task automatic cyc(input logic df, input logic [3:0] dv, input logic ef,
                     input logic cf, input logic sf);
    bus.digit_flag = df;
    bus.digit_val  = dv;
    bus.enter_flag = ef;
    bus.clear_flag = cf;
    bus.set_flag   = sf;
    @(posedge Clk);
    @(negedge Clk);
    bus.digit_flag = 1'b0;
    bus.digit_val  = 4'd0;
    bus.enter_flag = 1'b0;
    bus.clear_flag = 1'b0;
    bus.set_flag   = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Digits taken from the most significant nibble; returns one cycle after CHECK.
  task automatic enter_code(input logic [15:0] c, input int ndig);
    for (int i = 0; i < ndig; i++) cyc(1'b1, c[15-4*i -: 4], 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic check_outs(input string name, input logic unl, input logic alm,
                            input logic err, input logic [3:0] cnt);
    check({name, ".unlocked"},  int'(bus.unlocked),  int'(unl));
    check({name, ".alarm"},     int'(bus.alarm),     int'(alm));
    check({name, ".err_pulse"}, int'(bus.err_pulse), int'(err));
    check({name, ".digit_cnt"}, int'(bus.digit_cnt), int'(cnt));
  endtask

  int n;

  initial begin
    n_pass  = 0;
    n_total = 0;
    Rst_n   = 1'b0;
    bus.digit_flag = 1'b0;
    bus.digit_val  = 4'd0;
    bus.enter_flag = 1'b0;
    bus.clear_flag = 1'b0;
    bus.set_flag   = 1'b0;

    //           name         df dv     ef cf sf  unl alm err cnt
    vecs[0]  = '{"d1",        1, 4'd1,  0, 0, 0,  0,  0,  0,  4'd1};
    vecs[1]  = '{"d2",        1, 4'd2,  0, 0, 0,  0,  0,  0,  4'd2};
    vecs[2]  = '{"d12_ign",   1, 4'd12, 0, 0, 0,  0,  0,  0,  4'd2};
    vecs[3]  = '{"d3",        1, 4'd3,  0, 0, 0,  0,  0,  0,  4'd3};
    vecs[4]  = '{"d4",        1, 4'd4,  0, 0, 0,  0,  0,  0,  4'd4};
    vecs[5]  = '{"d5_full",   1, 4'd5,  0, 0, 0,  0,  0,  0,  4'd4};
    vecs[6]  = '{"enter",     0, 4'd0,  1, 0, 0,  0,  0,  0,  4'd4};
    vecs[7]  = '{"check_ok",  0, 4'd0,  0, 0, 0,  1,  0,  0,  4'd0};
    vecs[8]  = '{"enter_set", 0, 4'd0,  1, 0, 1,  0,  0,  0,  4'd0};
    vecs[9]  = '{"relocked",  0, 4'd0,  0, 0, 0,  0,  0,  0,  4'd0};
    vecs[10] = '{"d7",        1, 4'd7,  0, 0, 0,  0,  0,  0,  4'd1};
    vecs[11] = '{"clr_dig",   1, 4'd8,  0, 1, 0,  0,  0,  0,  4'd0};
    vecs[12] = '{"f1",        1, 4'd1,  0, 0, 0,  0,  0,  0,  4'd1};
    vecs[13] = '{"f2",        1, 4'd2,  0, 0, 0,  0,  0,  0,  4'd2};
    vecs[14] = '{"f3",        1, 4'd3,  0, 0, 0,  0,  0,  0,  4'd3};
    vecs[15] = '{"f_enter",   0, 4'd0,  1, 0, 0,  0,  0,  0,  4'd3};
    vecs[16] = '{"f_err",     0, 4'd0,  0, 0, 0,  0,  0,  1,  4'd0};
    vecs[17] = '{"err_drop",  0, 4'd0,  0, 0, 0,  0,  0,  0,  4'd0};
    vecs[18] = '{"set_dig",   1, 4'd9,  0, 0, 1,  0,  0,  0,  4'd0};

    repeat (2) @(negedge Clk);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].df, vecs[i].dv, vecs[i].ef, vecs[i].cf, vecs[i].sf);
      check_outs(vecs[i].name, vecs[i].exp_unl, vecs[i].exp_alm,
                 vecs[i].exp_err, vecs[i].exp_cnt);
    end

    // Unlock duration: exactly UNLOCK_CYC cycles with unlocked high.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("t1.check_cycle", int'(bus.unlocked), 0);
    idle();
    check("t1.open", int'(bus.unlocked), 1);
    n = 1;
    while (bus.unlocked && n < 600) begin
      idle();
      if (bus.unlocked) n++;
    end
    check("t1.unlock_len", n, 500);
    check("t1.relocked", int'(bus.unlocked), 0);

    // Three short entries -> lockout; keys during alarm are ignored.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      enter_code(16'h1230, 3);
      check_outs("t2.fail", 1'b0, 1'b0, 1'b1, 4'd0);
    end
    enter_code(16'h1230, 3);
    check_outs("t2.lockout", 1'b0, 1'b1, 1'b1, 4'd0);
    n = 1;
    for (int k = 0; k < 1200 && bus.alarm; k++) begin
      if (k < 4)       cyc(1'b1, 4'(k + 1), 1'b0, 1'b0, 1'b0);
      else if (k == 4) cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      else if (k == 5) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      else             idle();
      if (k == 3) check("t2.cnt_in_alarm", int'(bus.digit_cnt), 0);
      if (bus.alarm) n++;
    end
    check("t2.alarm_len", n, 1000);
    check_outs("t2.after", 1'b0, 1'b0, 1'b0, 4'd0);
    enter_code(16'h1230, 3);
    check_outs("t2.fail_cnt_cleared", 1'b0, 1'b0, 1'b1, 4'd0);

    // Code change, including a short entry rejected inside SETPW.
    do_reset();
    enter_code(16'h1234, 4);
    check("t3.open", int'(bus.unlocked), 1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("t3.setpw_unl", int'(bus.unlocked), 1);
    cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_outs("t3.short_set", 1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(9 - i), 1'b0, 1'b0, 1'b0);
    check("t3.set_cnt", int'(bus.digit_cnt), 4);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_outs("t3.stored", 1'b0, 1'b0, 1'b0, 4'd0);
    enter_code(16'h1234, 4);
    check_outs("t3.old_code", 1'b0, 1'b0, 1'b1, 4'd0);
    enter_code(16'h9876, 4);
    check_outs("t3.new_code", 1'b1, 1'b0, 1'b0, 4'd0);

    // Reset mid-SETPW after a second code change restores the default code.
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    enter_code(16'h5555, 4);
    check("t6.open_5555", int'(bus.unlocked), 1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_outs("t6.reset", 1'b0, 1'b0, 1'b0, 4'd0);
    enter_code(16'h1234, 4);
    check("t6.default_code", int'(bus.unlocked), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
